// File: rtl/trap_ctrl_if.sv
// Bundle between trap_ctrl, the execute stage and the CSR file.
// The slave side is the trap sequencer; the master side drives instructions and CSR state.
interface trap_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            ext_irq;
  logic [XLEN-1:0] mstatus_in;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  inst_valid, inst, pc, ext_irq, mstatus_in, mtvec_in, mepc_in,
    output csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc
  );

  modport master (
    output inst_valid, inst, pc, ext_irq, mstatus_in, mtvec_in, mepc_in,
    input  csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects ECALL/UNIMP/MRET/external interrupt, serialises the
// mepc/mcause/mstatus writes through the single CSR write port, then redirects the PC.
module trap_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  bus
);

  localparam logic [31:0] InstEcall = 32'h0000_0073;
  localparam logic [31:0] InstMret  = 32'h3020_0073;
  localparam logic [31:0] InstUnimp = 32'hC000_1073;

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;

  localparam logic [XLEN-1:0] CauseIrq   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CauseIll   = XLEN'(2);
  localparam logic [XLEN-1:0] CauseEcall = XLEN'(11);

  typedef enum logic [2:0] {
    StIdle,
    StWEpc,
    StWCause,
    StWStatus,
    StRedir
  } state_e;

  typedef enum logic {
    KindTrap,
    KindRet
  } kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] status_q, status_d;

  logic            irq_pend, is_ecall, is_mret, is_unimp;
  logic [XLEN-1:0] status_trap, status_ret, tvec_base, tvec_target;

  // Detection is held off while reset is asserted so stall is 0 during reset.
  assign irq_pend = ~rst & bus.inst_valid & bus.ext_irq & bus.mstatus_in[3];
  assign is_ecall = ~rst & bus.inst_valid & (bus.inst == InstEcall);
  assign is_mret  = ~rst & bus.inst_valid & (bus.inst == InstMret);
  assign is_unimp = ~rst & bus.inst_valid & (bus.inst == InstUnimp);

  always_comb begin
    status_trap        = status_q;
    status_trap[7]     = status_q[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;

    status_ret         = status_q;
    status_ret[3]      = status_q[7];
    status_ret[7]      = 1'b1;
    status_ret[12:11]  = 2'b11;

    tvec_base   = bus.mtvec_in & ~XLEN'(3);
    tvec_target = tvec_base;
    // Vectored mode only applies to interrupts; exceptions always go to the base.
    if (bus.mtvec_in[1:0] == 2'b01 && cause_q[XLEN-1]) begin
      tvec_target = tvec_base + XLEN'({cause_q[4:0], 2'b00});
    end
  end

  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    epc_d           = epc_q;
    cause_d         = cause_q;
    status_d        = status_q;
    bus.csr_we      = 1'b0;
    bus.csr_waddr   = '0;
    bus.csr_wdata   = '0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    unique case (state_q)
      StIdle: begin
        if (irq_pend || is_unimp || is_ecall || is_mret) begin
          bus.stall = 1'b1;
          epc_d     = bus.pc;
          status_d  = bus.mstatus_in;
          if (irq_pend || is_unimp || is_ecall) begin
            kind_d  = KindTrap;
            state_d = StWEpc;
            if (irq_pend)      cause_d = CauseIrq;
            else if (is_unimp) cause_d = CauseIll;
            else               cause_d = CauseEcall;
          end else begin
            kind_d  = KindRet;
            state_d = StWStatus;
          end
        end
      end
      StWEpc: begin
        bus.stall     = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = AddrMepc;
        bus.csr_wdata = epc_q;
        state_d       = StWCause;
      end
      StWCause: begin
        bus.stall     = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = AddrMcause;
        bus.csr_wdata = cause_q;
        state_d       = StWStatus;
      end
      StWStatus: begin
        bus.stall     = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = AddrMstatus;
        bus.csr_wdata = (kind_q == KindRet) ? status_ret : status_trap;
        state_d       = StRedir;
      end
      StRedir: begin
        bus.stall       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = (kind_q == KindRet) ? bus.mepc_in : tvec_target;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      kind_q   <= KindTrap;
      epc_q    <= '0;
      cause_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: checks every cycle of each trap/return sequence against
// hand-computed CSR writes and redirect targets.
module tb_trap_ctrl;

  localparam logic [31:0] Ecall = 32'h0000_0073;
  localparam logic [31:0] Mret  = 32'h3020_0073;
  localparam logic [31:0] Unimp = 32'hC000_1073;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_passed;

  trap_ctrl_if #(.XLEN(32)) bus ();

  trap_ctrl #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [11:0] addr,
                            input logic [31:0] data, input logic stall, input logic redir,
                            input logic [31:0] rpc);
    check_eq({tag, ".we"},    32'(bus.csr_we),      32'(we));
    check_eq({tag, ".addr"},  32'(bus.csr_waddr),   32'(addr));
    check_eq({tag, ".data"},  bus.csr_wdata,        data);
    check_eq({tag, ".stall"}, 32'(bus.stall),       32'(stall));
    check_eq({tag, ".redir"}, 32'(bus.redirect),    32'(redir));
    check_eq({tag, ".rpc"},   bus.redirect_pc,      rpc);
  endtask

  // Checks the current cycle at the falling edge, then moves just past the next rising edge.
  task automatic cyc(input string tag, input logic we, input logic [11:0] addr,
                     input logic [31:0] data, input logic stall, input logic redir,
                     input logic [31:0] rpc);
    @(negedge clk);
    check_outs(tag, we, addr, data, stall, redir, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.pc         = '0;
    bus.ext_irq    = 1'b0;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc, input logic irq);
    bus.inst_valid = 1'b1;
    bus.inst       = inst;
    bus.pc         = pc;
    bus.ext_irq    = irq;
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    n_checks   = 0;
    n_passed   = 0;
    idle_inputs();
    bus.mstatus_in = '0;
    bus.mtvec_in   = '0;
    bus.mepc_in    = '0;

    #2;
    check_outs("reset", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Non-trap encodings and invalid instructions are ignored.
    present(32'h0000_0013, 32'h10, 1'b0);
    cyc("nop", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.inst_valid = 1'b0;
    bus.inst       = Ecall;
    cyc("inv_ecall", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // ECALL; live mstatus changes after detect must not leak into the mstatus write.
    bus.mstatus_in = 32'h8;
    bus.mtvec_in   = 32'h200;
    present(Ecall, 32'h100, 1'b0);
    cyc("ec.T0", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle_inputs();
    bus.mstatus_in = 32'h0;
    cyc("ec.T1", 1'b1, 12'h341, 32'h100, 1'b1, 1'b0, 32'h0);
    cyc("ec.T2", 1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 32'h0);
    cyc("ec.T3", 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    cyc("ec.T4", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h200);
    cyc("ec.T5", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // UNIMP with masked interrupt; vectored mtvec does not apply to exceptions.
    bus.mstatus_in = 32'h0;
    bus.mtvec_in   = 32'h301;
    present(Unimp, 32'h80, 1'b1);
    cyc("ill.T0", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle_inputs();
    cyc("ill.T1", 1'b1, 12'h341, 32'h80, 1'b1, 1'b0, 32'h0);
    cyc("ill.T2", 1'b1, 12'h342, 32'h2, 1'b1, 1'b0, 32'h0);
    cyc("ill.T3", 1'b1, 12'h300, 32'h1800, 1'b1, 1'b0, 32'h0);
    cyc("ill.T4", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h300);
    cyc("ill.T5", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Interrupt preempting an ECALL, vectored handler: 0x300 + 4*11.
    bus.mstatus_in = 32'h8;
    bus.mtvec_in   = 32'h301;
    present(Ecall, 32'h40, 1'b1);
    cyc("irq.T0", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle_inputs();
    cyc("irq.T1", 1'b1, 12'h341, 32'h40, 1'b1, 1'b0, 32'h0);
    cyc("irq.T2", 1'b1, 12'h342, 32'h8000_000B, 1'b1, 1'b0, 32'h0);
    cyc("irq.T3", 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    cyc("irq.T4", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h32C);
    cyc("irq.T5", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // MRET: stall exactly T..T+2.
    bus.mstatus_in = 32'h1880;
    bus.mepc_in    = 32'h104;
    present(Mret, 32'h500, 1'b0);
    cyc("ret.T0", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle_inputs();
    cyc("ret.T1", 1'b1, 12'h300, 32'h1888, 1'b1, 1'b0, 32'h0);
    cyc("ret.T2", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h104);
    cyc("ret.T3", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Back-to-back ECALLs with an ignored interrupt pulse during W_EPC.
    bus.mstatus_in = 32'h8;
    bus.mtvec_in   = 32'h200;
    present(Ecall, 32'h100, 1'b0);
    cyc("b2b.T0", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    bus.ext_irq = 1'b1;
    cyc("b2b.T1", 1'b1, 12'h341, 32'h100, 1'b1, 1'b0, 32'h0);
    bus.ext_irq = 1'b0;
    cyc("b2b.T2", 1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 32'h0);
    cyc("b2b.T3", 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    cyc("b2b.T4", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h200);
    bus.pc = 32'h200;
    cyc("b2b.T5", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle_inputs();
    cyc("b2b.T6", 1'b1, 12'h341, 32'h200, 1'b1, 1'b0, 32'h0);
    cyc("b2b.T7", 1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 32'h0);
    cyc("b2b.T8", 1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 32'h0);
    cyc("b2b.T9", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h200);
    cyc("b2b.T10", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset asserted during W_CAUSE abandons the sequence at once.
    present(Ecall, 32'h180, 1'b0);
    cyc("rst.T0", 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle_inputs();
    cyc("rst.T1", 1'b1, 12'h341, 32'h180, 1'b1, 1'b0, 32'h0);
    #1;
    check_outs("rst.pre", 1'b1, 12'h342, 32'hB, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check_outs("rst.async", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("rst.after%0d", i), 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the decode/execute stage and the CSR register file of the single-issue RISC-V core. Detects ECALL, UNIMP (illegal), MRET and a gated external interrupt at instruction boundaries. Stalls the pipeline while it issues the required CSR updates one per cycle through the CSR file's single write port. Then redirects the PC to the handler or the return address.

## Interface

Parameters:
- `XLEN`, default 32: data and address width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `inst_valid`, in, 1: `inst`/`pc` hold a valid instruction at its execute boundary.
- `inst`, in, 32: instruction word.
- `pc`, in, XLEN: address of `inst`.
- `ext_irq`, in, 1: level-sensitive machine external interrupt request.
- `mstatus_in`, in, XLEN: current mstatus from the CSR file.
- `mtvec_in`, in, XLEN: current mtvec.
- `mepc_in`, in, XLEN: current mepc.
- `csr_we`, out, 1: CSR write strobe.
- `csr_waddr`, out, 12: CSR write address.
- `csr_wdata`, out, XLEN: CSR write data.
- `stall`, out, 1: freeze fetch/decode and suppress pipeline CSR and register writes.
- `redirect`, out, 1: one-cycle pulse; load `redirect_pc` into the PC.
- `redirect_pc`, out, XLEN: target PC.

## Operation

- Decode, valid only with `inst_valid`=1:
  - ECALL = 0x00000073
  - MRET = 0x30200073
  - UNIMP = 0xC0001073
  - Other encodings are ignored.
- Interrupt pending = `ext_irq` & `mstatus_in[3]` (MIE).
- Priority in IDLE: interrupt > UNIMP > ECALL > MRET. An interrupt preempts the instruction; that instruction is not executed and its `pc` is saved.
- Values captured on the detect edge:
  - `epc_q` ← `pc`.
  - `cause_q`:
    - interrupt → 0x8000000B
    - UNIMP → 0x00000002
    - ECALL → 0x0000000B
  - `status_q` ← `mstatus_in`.
  - `kind_q` ∈ {TRAP, RET}.
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, REDIR.
- TRAP path: IDLE → W_EPC → W_CAUSE → W_STATUS → REDIR → IDLE.
  - W_EPC: `csr_we`=1, addr 0x341, data `epc_q`.
  - W_CAUSE: `csr_we`=1, addr 0x342, data `cause_q`.
  - W_STATUS: `csr_we`=1, addr 0x300, data = `status_q` with:
    - bit7 (MPIE) ← `status_q[3]`
    - bit3 (MIE) ← 0
    - bits[12:11] (MPP) ← 2'b11
    - all other bits unchanged.
  - REDIR: `redirect`=1, with target:
    - base = `mtvec_in & ~3`
    - if `mtvec_in[1:0]`=01 and the trap is an interrupt: target = base + 4·(`cause_q[4:0]`), computed mod 2^XLEN
    - otherwise: target = base.
- RET path: IDLE → W_STATUS → REDIR → IDLE.
  - W_STATUS: mstatus data = `status_q` with:
    - bit3 (MIE) ← `status_q[7]`
    - bit7 (MPIE) ← 1
    - MPP ← 2'b11
  - REDIR: `redirect_pc` = `mepc_in`.
- `csr_waddr`/`csr_wdata` are 0 whenever `csr_we`=0.
- `redirect_pc` is 0 whenever `redirect`=0.
- Outside IDLE, `inst`, `inst_valid` and `ext_irq` are ignored. A request that is still pending is re-evaluated only after returning to IDLE.

## Timing

- Reset: state IDLE; `csr_we`, `csr_waddr`, `csr_wdata`, `stall`, `redirect`, `redirect_pc` all 0; captured registers 0.
- Reset asserted mid-sequence: the sequence is abandoned immediately. Outputs go to 0 asynchronously. No further CSR writes or redirect occur.
- `stall` = (state ≠ IDLE) | (IDLE & a trap/MRET is detected this cycle). It is combinational, so the detecting instruction is held in the same cycle.
- Trap latency, with detect in cycle T:
  - CSR writes in T+1, T+2, T+3
  - `redirect` in T+4
  - `stall` high in T..T+4
  - first handler fetch in T+5.
- MRET latency: mstatus write in T+1; `redirect` in T+2; `stall` high in T..T+2.
- The CSR file samples writes on the edge ending each W_* cycle. W_STATUS data comes from `status_q`, never from live `mstatus_in`.
- REDIR reads `mtvec_in`/`mepc_in` live. This is safe because the pipeline cannot write CSRs while `stall`=1.
- Back-to-back: if a new trap is present in the IDLE cycle right after REDIR, it is detected there. There is no dead cycle beyond REDIR.

## Test plan

- Reset mid-W_CAUSE → outputs go to 0 immediately. After release: IDLE, no mstatus write, `stall`=0.
- ECALL with `pc`=0x100, mtvec=0x200, mstatus=0x8 → writes, in order:
  - 0x341←0x100
  - 0x342←0xB
  - 0x300←0x1880
  - then `redirect` to 0x200 at T+4.
- UNIMP with `ext_irq`=1 and MIE=0 → cause 0x2 (interrupt masked).
- `ext_irq`=1, MIE=1, mtvec=0x301 (vectored), `pc`=0x40 holding ECALL → cause 0x8000000B, mepc 0x40, redirect 0x32C.
- MRET with mstatus=0x1880, mepc=0x104 → 0x300←0x1888 at T+1, redirect 0x104 at T+2, `stall` high for exactly 3 cycles.
- ECALL presented in the IDLE cycle immediately after a REDIR → second sequence starts with no gap. `ext_irq` pulses during W_EPC are ignored.
